e203_itcm_icb_arbt: RTL
=======================

Name: e203_itcm_icb_arbt

Overview:
- Shares the single ITCM ICB port between two requesters: the IFU instruction-fetch path (read-only) and the LSU load/store path.
- Arbitrates the command channel and tracks outstanding transactions in order, so each response is returned to the requester that issued it.
- Generates ifu_holdup, which tells the fetch path that the ITCM output still holds the IFU's last read data.
- Sits between the fetch ICB converter / LSU and the ITCM RAM controller.

Parameters:
AW, 16, ITCM ICB address width (matches E203_ITCM_ADDR_WIDTH)
DW, 64, ITCM data width; wmask width is DW/8
OUTS, 2, maximum outstanding ITCM transactions (depth of the ownership FIFO, >=1)
STARVE_MAX, 4, LSU-win count after which the IFU is forced to win (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ifu_icb_cmd_valid  in  1  IFU command valid
ifu_icb_cmd_ready  out  1  IFU command ready
ifu_icb_cmd_addr  in  AW  IFU fetch address (always a read)
ifu_icb_rsp_valid  out  1  IFU response valid
ifu_icb_rsp_ready  in  1  IFU response ready
ifu_icb_rsp_err  out  1  IFU response error
ifu_icb_rsp_rdata  out  DW  IFU read data
lsu_icb_cmd_valid  in  1  LSU command valid
lsu_icb_cmd_ready  out  1  LSU command ready
lsu_icb_cmd_addr  in  AW  LSU address
lsu_icb_cmd_read  in  1  1=read, 0=write
lsu_icb_cmd_wdata  in  DW  LSU write data
lsu_icb_cmd_wmask  in  DW/8  LSU byte mask
lsu_icb_rsp_valid  out  1  LSU response valid
lsu_icb_rsp_ready  in  1  LSU response ready
lsu_icb_rsp_err  out  1  LSU response error
lsu_icb_rsp_rdata  out  DW  LSU read data
itcm_icb_cmd_valid  out  1  ITCM command valid
itcm_icb_cmd_ready  in  1  ITCM command ready
itcm_icb_cmd_addr  out  AW  ITCM address
itcm_icb_cmd_read  out  1  ITCM read/write
itcm_icb_cmd_wdata  out  DW  ITCM write data
itcm_icb_cmd_wmask  out  DW/8  ITCM byte mask
itcm_icb_rsp_valid  in  1  ITCM response valid
itcm_icb_rsp_ready  out  1  ITCM response ready
itcm_icb_rsp_err  in  1  ITCM response error
itcm_icb_rsp_rdata  in  DW  ITCM read data
ifu_holdup  out  1  ITCM output still holds the IFU's last read data

Behaviour:
- Grant (combinational):
  - sel_lsu = lsu_icb_cmd_valid & ~force_ifu; otherwise the IFU is selected.
  - itcm_icb_cmd_valid = (lsu_valid | ifu_valid) & ~fifo_full.
  - Address/read/wdata/wmask are muxed from the selected requester; for the IFU, read=1, wdata=0, wmask=0.
- Ready:
  - lsu_icb_cmd_ready = sel_lsu & itcm_icb_cmd_ready & ~fifo_full.
  - ifu_icb_cmd_ready = ~sel_lsu & itcm_icb_cmd_ready & ~fifo_full.
  - The loser always sees ready=0.
- Ownership FIFO:
  - OUTS entries, 1 bit each (1=LSU).
  - Push the owner on an ITCM cmd handshake; pop on an ITCM rsp handshake.
  - Full blocks new commands even if a pop happens in the same cycle; there is no rsp_ready->cmd_ready combinational path.
  - Simultaneous push and pop when not full is allowed; the count is unchanged.
- Response routing (in order, by FIFO head):
  - ifu_icb_rsp_valid = itcm_icb_rsp_valid & ~empty & ~head.
  - lsu_icb_rsp_valid = itcm_icb_rsp_valid & ~empty & head.
  - itcm_icb_rsp_ready = ~empty & (head ? lsu_icb_rsp_ready : ifu_icb_rsp_ready).
  - rdata/err are fanned to both requesters unmodified.
  - When the FIFO is empty, itcm_icb_rsp_ready=0 and both rsp_valid=0.
- ifu_holdup register:
  - Set on an IFU cmd handshake.
  - Cleared on an LSU cmd handshake (read or write).
  - Otherwise holds its value.
- Latency: zero added cycles on cmd and rsp; the block is purely pass-through apart from the bookkeeping registers.
- Reset (rst=1 at a clock edge), regardless of in-flight traffic:
  - FIFO empties; ifu_holdup=0; starvation counter=0.
  - Outputs after reset: all cmd/rsp valid and ready outputs 0 until inputs are asserted.
  - Responses for transactions issued before reset are dropped (rsp_ready=0 because the FIFO is empty).

Optional Feature:
- Macro: E203_ITCM_ARBT_STARVE_EN.
- Enabled:
  - A 3-bit saturating counter increments on each LSU cmd handshake that occurs while ifu_icb_cmd_valid=1.
  - force_ifu = (cnt >= STARVE_MAX) & ifu_icb_cmd_valid.
  - The counter clears on an IFU cmd handshake.
- Disabled: force_ifu=0 (strict LSU priority) and no counter is instantiated.

Test Plan:
- IFU read addr 0x0040 alone, ITCM ready, rsp next cycle rdata=0x1122334455667788 -> ifu rsp_valid with that data; lsu rsp_valid=0; ifu_holdup=1.
- IFU and LSU valid in the same cycle (LSU write 0x0080, wmask=0xFF) -> LSU granted, ifu cmd_ready=0; ifu_holdup goes 0 after the handshake.
- OUTS=2: issue IFU then LSU back-to-back, ITCM rsp delayed -> third request sees cmd_ready=0; responses route IFU first, then LSU.
- Response on IFU head with ifu_icb_rsp_ready=0 -> itcm_icb_rsp_ready=0; data held until ready=1.
- rst asserted with 2 outstanding -> next cycle FIFO empty; spurious itcm_icb_rsp_valid=1 produces no requester rsp_valid; ifu_holdup=0.
- STARVE_EN, STARVE_MAX=4: both valid continuously -> 4 LSU grants, then 1 IFU grant, then LSU again.

Source files
------------

// File: rtl/e203_itcm_icb_arbt_if.sv
// ---------------------------------------------------------------------------
// e203_itcm_icb_arbt_if
//   One ICB link: a command channel (valid/ready/addr/read/wdata/wmask) and
//   a response channel (valid/ready/err/rdata).
//   master modport : drives the command, accepts the response
//   slave  modport : accepts the command, drives the response
// Parameters: AW address width, DW data width (wmask is DW/8 bits).
// ---------------------------------------------------------------------------
interface e203_itcm_icb_arbt_if #(
    parameter int AW = 16,
    parameter int DW = 64
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_read;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/e203_itcm_icb_arbt.sv
// ---------------------------------------------------------------------------
// e203_itcm_icb_arbt
//   Shares the ITCM ICB port between the IFU fetch path (read-only) and the
//   LSU. LSU has priority on the command channel; an in-order ownership FIFO
//   steers each ITCM response back to the requester that issued it.
//   ifu_holdup flags that the ITCM output still holds the IFU's last read.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   ifu         ICB slave side for the IFU (cmd_read/wdata/wmask ignored,
//               IFU commands are always reads)
//   lsu         ICB slave side for the LSU
//   itcm        ICB master side toward the ITCM RAM controller
//   ifu_holdup  1 after an IFU cmd handshake until the next LSU handshake
//
// Optional feature (macro E203_ITCM_ARBT_STARVE_EN):
//   A 3-bit saturating counter of LSU wins taken while the IFU was waiting;
//   once it reaches STARVE_MAX the IFU is forced to win the next grant.
//   Without the macro the LSU has strict priority and no counter exists.
// ---------------------------------------------------------------------------
module e203_itcm_icb_arbt #(
    parameter int AW         = 16,
    parameter int DW         = 64,
    parameter int OUTS       = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    e203_itcm_icb_arbt_if.slave      ifu,
    e203_itcm_icb_arbt_if.slave      lsu,
    e203_itcm_icb_arbt_if.master     itcm,
    output logic                     ifu_holdup
);
    localparam int CW = $clog2(OUTS + 1);

    if (OUTS < 1 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_param_chk
        $error("e203_itcm_icb_arbt: OUTS must be >=1 and STARVE_MAX in 1..7");
    end

    logic            force_ifu;
    logic            sel_lsu;
    logic            fifo_full;
    logic            fifo_empty;
    logic            head;
    logic            push;
    logic            pop;
    logic            ifu_hs;
    logic            lsu_hs;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   wr_idx;
    logic [OUTS-1:0] own;
    logic [OUTS-1:0] own_nxt;

    // ---------------- command grant ----------------
    assign sel_lsu   = lsu.cmd_valid & ~force_ifu;
    assign fifo_full = (cnt == CW'(OUTS));
    assign fifo_empty = (cnt == '0);
    assign head      = own[0];

    assign itcm.cmd_valid = (lsu.cmd_valid | ifu.cmd_valid) & ~fifo_full;
    assign itcm.cmd_addr  = sel_lsu ? lsu.cmd_addr  : ifu.cmd_addr;
    assign itcm.cmd_read  = sel_lsu ? lsu.cmd_read  : 1'b1;
    assign itcm.cmd_wdata = sel_lsu ? lsu.cmd_wdata : '0;
    assign itcm.cmd_wmask = sel_lsu ? lsu.cmd_wmask : '0;

    // Full gates ready on the occupancy alone, so a same-cycle pop never
    // opens a path from rsp_ready to cmd_ready.
    assign lsu.cmd_ready =  sel_lsu & itcm.cmd_ready & ~fifo_full;
    assign ifu.cmd_ready = ~sel_lsu & itcm.cmd_ready & ~fifo_full;

    assign lsu_hs = lsu.cmd_valid & lsu.cmd_ready;
    assign ifu_hs = ifu.cmd_valid & ifu.cmd_ready;

    // ---------------- response routing ----------------
    assign ifu.rsp_valid = itcm.rsp_valid & ~fifo_empty & ~head;
    assign lsu.rsp_valid = itcm.rsp_valid & ~fifo_empty &  head;
    assign itcm.rsp_ready = ~fifo_empty & (head ? lsu.rsp_ready : ifu.rsp_ready);
    assign ifu.rsp_err   = itcm.rsp_err;
    assign lsu.rsp_err   = itcm.rsp_err;
    assign ifu.rsp_rdata = itcm.rsp_rdata;
    assign lsu.rsp_rdata = itcm.rsp_rdata;

    // ---------------- ownership FIFO ----------------
    // Stored as a shift register: entry 0 is the head, a pop shifts down and
    // a push lands just past the last valid entry (after any shift).
    assign push   = itcm.cmd_valid & itcm.cmd_ready;
    assign pop    = itcm.rsp_valid & itcm.rsp_ready;
    assign wr_idx = cnt - CW'(pop);

    always_comb begin
        own_nxt = own;
        if (pop)
            own_nxt = own >> 1;
        if (push) begin
            for (int i = 0; i < OUTS; i++) begin
                if (CW'(i) == wr_idx)
                    own_nxt[i] = sel_lsu;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            own <= '0;
        end else begin
            cnt <= cnt + CW'(push) - CW'(pop);
            own <= own_nxt;
        end
    end

    // ---------------- ifu_holdup ----------------
    always_ff @(posedge clk) begin
        if (rst)
            ifu_holdup <= 1'b0;
        else if (ifu_hs)
            ifu_holdup <= 1'b1;
        else if (lsu_hs)
            ifu_holdup <= 1'b0;
    end

    // ---------------- starvation guard ----------------
`ifdef E203_ITCM_ARBT_STARVE_EN
    localparam logic [2:0] SMAX = 3'(STARVE_MAX);
    logic [2:0] starve_cnt;

    assign force_ifu = (starve_cnt >= SMAX) & ifu.cmd_valid;

    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= 3'd0;
        else if (ifu_hs)
            starve_cnt <= 3'd0;
        else if (lsu_hs && ifu.cmd_valid && starve_cnt != 3'd7)
            starve_cnt <= starve_cnt + 3'd1;
    end
`else
    assign force_ifu = 1'b0;
`endif

endmodule
